sad_divider: RTL and testbench
==============================

Name: sad_divider

Overview:
- Sequential shift-subtract (restoring) unsigned divider; the inverse of the team's shift-add multiplier (SAM).
- Accepts a 2W-bit dividend and a W-bit divisor on a Start pulse and produces a 2W-bit quotient and a W-bit remainder after a fixed iteration count.
- Result width matches the multiplier product, so a SAM Product can be fed straight back in for round-trip checks.

Parameters:
- WIDTH, 8, divisor/remainder width; dividend/quotient width is 2*WIDTH.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request; sampled on rising edge.
- Dividend  input  2*WIDTH  numerator; sampled only on the accepting edge.
- Divisor  input  WIDTH  denominator; sampled only on the accepting edge.
- Quotient  output  2*WIDTH  registered result.
- Remainder  output  WIDTH  registered result.
- Done  output  1  high while a valid result is held.
- DivByZero  output  1  high with Done when the captured Divisor was 0.

Behaviour:
- Reset (Reset=0, async): state to IDLE; Quotient=0, Remainder=0, Done=0, DivByZero=0; internal counter and working registers cleared. Applies immediately, including mid-CALC; the in-flight operation is discarded.
- States:
  - IDLE: after reset.
  - CALC: iterating.
  - DONE: result held.
- Start acceptance:
  - Accepted in IDLE or DONE only.
  - Start during CALC is ignored: no capture, no restart, no effect on the result.
- On the accepting edge:
  - Capture Dividend into working quotient register Q (2W bits); clear partial remainder R (W+1 bits); load count=2W.
  - Clear Done and DivByZero. Quotient/Remainder outputs keep their previous values.
- Divisor==0 at capture:
  - On that same edge go to DONE, with Done=1, DivByZero=1, Quotient=all ones, Remainder=Dividend[W-1:0].
  - Latency is 1 edge.
- Normal capture: go to CALC.
- CALC, each edge:
  - T = {R[W-1:0], Q[2W-1]}.
  - If T >= {1'b0,Divisor}: R = T - Divisor and Q = {Q[2W-2:0],1}; else R = T and Q = {Q[2W-2:0],0}.
  - count decrements.
- On the edge where count goes 1->0: load Quotient=Q (final), Remainder=R[W-1:0]; set Done=1; state to DONE.
- Latency:
  - Done is first seen high after the 2W-th edge following the accepting edge (2W+1 edges including capture; 17 for WIDTH=8).
  - Done rises exactly once per operation and stays high until the next accepted Start or reset.
- Results hold stable throughout DONE.
- Start held high continuously: re-accepted on every edge in which the state is IDLE/DONE, giving back-to-back operations.
- Arithmetic:
  - Unsigned only.
  - Invariant: Dividend == Quotient*Divisor + Remainder with Remainder < Divisor.
  - Quotient never overflows, since the quotient width is 2W.

Decomposition:
- Shared definitions file (included by SAM, sad_divider and benches): state encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2; default WIDTH=8.
- One natural sub-module: sad_div_step, a combinational single iteration (inputs R, Q, Divisor; outputs next R, next Q). It is instantiated once in the sequential wrapper.
- Counter and FSM stay in the top module.

Test Plan:
- Reset low 20ns, release; Dividend=120, Divisor=10, Start one cycle -> Done rises exactly 17 edges after accept; Quotient=12, Remainder=0, DivByZero=0.
- Dividend=100, Divisor=7 -> Quotient=14, Remainder=2. Then Dividend=63750, Divisor=250 -> Quotient=255, Remainder=0. Then Dividend=65535, Divisor=1 -> Quotient=65535, Remainder=0.
- Dividend=300, Divisor=0 -> Done and DivByZero high 1 edge after accept; Quotient=16'hFFFF, Remainder=8'd44 (300 low byte).
- Dividend=1000, Divisor=3, then Start pulsed again with Dividend=5, Divisor=5 at edge 5 of CALC -> second Start ignored; Quotient=333, Remainder=1.
- Start 255/250 and assert Reset low at edge 8 of CALC -> all outputs 0 immediately, asynchronously; after release, 15/4 -> Quotient=3, Remainder=3.
- Round trip: SAM computes 251*3=753, fed to sad_divider with Divisor=3 -> Quotient=251, Remainder=0; then a random sweep of 200 pairs checks the invariant.

Source files
------------

// File: rtl/sad_divider_pkg.sv
// Shared definitions for the shift-subtract divider and its companion multiplier:
// FSM state encoding and default operand width.
package sad_divider_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sad_divider_if.sv
// Request/result bundle for sad_divider; signal prefixes are from the divider's view.
interface sad_divider_if
  import sad_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic                   i_start;
  logic [2*WIDTH-1:0]     i_dividend;
  logic [WIDTH-1:0]       i_divisor;
  logic [2*WIDTH-1:0]     o_quotient;
  logic [WIDTH-1:0]       o_remainder;
  logic                   o_done;
  logic                   o_div_by_zero;

  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_quotient, o_remainder, o_done, o_div_by_zero
  );

  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_quotient, o_remainder, o_done, o_div_by_zero
  );

endinterface

// File: rtl/sad_divider_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
module sad_div_step
  import sad_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]   i_r,
  input  logic [2*WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic [WIDTH-1:0]   o_r,
  output logic [2*WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_t;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  // The partial remainder is always below the divisor, so its top bit of the
  // W+1-bit form is zero and only W bits are carried between iterations.
  assign w_t    = {i_r, i_q[2*WIDTH-1]};
  assign w_fits = (w_t >= {1'b0, i_divisor});
  assign w_diff = w_t - {1'b0, i_divisor};

  always_comb begin
    o_r = w_t[WIDTH-1:0];
    o_q = {i_q[2*WIDTH-2:0], 1'b0};
    if (w_fits) begin
      o_r = w_diff[WIDTH-1:0];
      o_q = {i_q[2*WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/sad_divider.sv
// Sequential restoring unsigned divider: 2W-bit dividend / W-bit divisor,
// 2W iterations after the accepting edge; divide-by-zero resolves on capture.
module sad_divider
  import sad_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  sad_divider_if.slave io_bus
);

  localparam int unsigned CW = $clog2(2*WIDTH+1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [2*WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]     r_r;
  logic [WIDTH-1:0]     r_div;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]     r_rem;
  logic                 r_done;
  logic                 r_dbz;

  logic [2*WIDTH-1:0]   w_q_nxt;
  logic [WIDTH-1:0]     w_r_nxt;
  logic                 w_accept;
  logic                 w_div_zero;
  logic                 w_last;

  assign w_accept   = io_bus.i_start && (r_state != CALC);
  assign w_div_zero = (io_bus.i_divisor == '0);
  assign w_last     = (r_cnt == CW'(1));

  sad_div_step #(.WIDTH(WIDTH)) u_step (
    .i_r       (r_r),
    .i_q       (r_q),
    .i_divisor (r_div),
    .o_r       (w_r_nxt),
    .o_q       (w_q_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: if (w_accept) w_state_nxt = w_div_zero ? DONE : CALC;
      CALC:       if (w_last)   w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q    <= '0;
      r_r    <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_q    <= io_bus.i_dividend;
      r_r    <= '0;
      r_div  <= io_bus.i_divisor;
      r_cnt  <= CW'(2*WIDTH);
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      if (w_div_zero) begin
        r_done <= 1'b1;
        r_dbz  <= 1'b1;
        r_quot <= '1;
        r_rem  <= io_bus.i_dividend[WIDTH-1:0];
      end
    end else if (r_state == CALC) begin
      r_q   <= w_q_nxt;
      r_r   <= w_r_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_quot <= w_q_nxt;
        r_rem  <= w_r_nxt;
        r_done <= 1'b1;
      end
    end
  end

  assign io_bus.o_quotient    = r_quot;
  assign io_bus.o_remainder   = r_rem;
  assign io_bus.o_done        = r_done;
  assign io_bus.o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_sad_divider.sv
// Directed and random checks of sad_divider against plain integer division.
module tb_sad_divider;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  sad_divider_if #(.WIDTH(8)) bus ();

  sad_divider #(.WIDTH(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int unsigned lat);
    logic [15:0] prev_q;
    @(negedge clk);
    prev_q        = bus.o_quotient;
    bus.i_start   = 1'b1;
    bus.i_dividend = a;
    bus.i_divisor = b;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    lat = 1;
    if (b != 8'd0) begin
      chk("hold_q", 32'(bus.o_quotient), 32'(prev_q));
      chk("done_clr", 32'(bus.o_done), 32'd0);
    end
    while (!bus.o_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b,
                              input int unsigned lat);
    int unsigned exp_q, exp_r, exp_lat;
    if (b == 8'd0) begin
      exp_q = 32'hFFFF; exp_r = a % 256; exp_lat = 1;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_lat = 17;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_done"}, 32'(bus.o_done), 32'd1);
    chk({tag, "_q"}, 32'(bus.o_quotient), exp_q);
    chk({tag, "_r"}, 32'(bus.o_remainder), exp_r);
    chk({tag, "_dbz"}, 32'(bus.o_div_by_zero), (b == 8'd0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int unsigned lat;
    logic [15:0] a;
    logic [7:0]  b;

    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor = '0;
    #12;
    chk("rst_q", 32'(bus.o_quotient), 32'd0);
    chk("rst_r", 32'(bus.o_remainder), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_dbz", 32'(bus.o_div_by_zero), 32'd0);
    #8 rst_n = 1'b1;

    run_op(16'd120, 8'd10, lat);   check_result("d120_10", 16'd120, 8'd10, lat);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", 32'(bus.o_done), 32'd1);
    chk("q_hold", 32'(bus.o_quotient), 32'd12);
    run_op(16'd100, 8'd7, lat);    check_result("d100_7", 16'd100, 8'd7, lat);
    run_op(16'd63750, 8'd250, lat); check_result("d63750_250", 16'd63750, 8'd250, lat);
    run_op(16'd65535, 8'd1, lat);  check_result("d65535_1", 16'd65535, 8'd1, lat);
    run_op(16'd300, 8'd0, lat);    check_result("d300_0", 16'd300, 8'd0, lat);

    // Start pulse in the middle of CALC must be ignored.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_dividend = 16'd1000; bus.i_divisor = 8'd3;
    @(posedge clk); #1;
    bus.i_start = 1'b0; lat = 1;
    repeat (4) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_dividend = 16'd5; bus.i_divisor = 8'd5;
    @(posedge clk); #1;
    bus.i_start = 1'b0; lat++;
    while (!bus.o_done && lat < 40) begin @(posedge clk); #1; lat++; end
    check_result("ignore_start", 16'd1000, 8'd3, lat);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_dividend = 16'd255; bus.i_divisor = 8'd250;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", 32'(bus.o_quotient), 32'd0);
    chk("arst_r", 32'(bus.o_remainder), 32'd0);
    chk("arst_done", 32'(bus.o_done), 32'd0);
    chk("arst_dbz", 32'(bus.o_div_by_zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("arst_idle_done", 32'(bus.o_done), 32'd0);
    run_op(16'd15, 8'd4, lat);     check_result("d15_4", 16'd15, 8'd4, lat);

    // Start held high: re-accepted on the edge after completion.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_dividend = 16'd50; bus.i_divisor = 8'd5;
    @(posedge clk); #1;
    lat = 1;
    while (!bus.o_done && lat < 40) begin @(posedge clk); #1; lat++; end
    check_result("b2b_first", 16'd50, 8'd5, lat);
    @(negedge clk);
    bus.i_dividend = 16'd81; bus.i_divisor = 8'd9;
    @(posedge clk); #1;
    chk("b2b_reaccept", 32'(bus.o_done), 32'd0);
    bus.i_start = 1'b0; lat = 1;
    while (!bus.o_done && lat < 40) begin @(posedge clk); #1; lat++; end
    check_result("b2b_second", 16'd81, 8'd9, lat);

    // Round trip through a multiplier product.
    a = 16'(251 * 3);
    run_op(a, 8'd3, lat);          check_result("round_trip", a, 8'd3, lat);
    chk("round_trip_val", 32'(bus.o_quotient), 32'd251);

    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom);
      b = 8'($urandom_range(0, 255));
      run_op(a, b, lat);
      check_result("rand", a, b, lat);
      if (b != 8'd0) begin
        chk("rand_inv", 32'(bus.o_quotient) * 32'(b) + 32'(bus.o_remainder), 32'(a));
        chk("rand_rem_lt", 32'(bus.o_remainder < b), 32'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
